// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and default sizing for the memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN0     = 2'd1,
        OWN1     = 2'd2
    } owner_e;

    localparam int unsigned DEF_M         = 3;
    localparam int unsigned DEF_N         = 4;
    localparam int unsigned DEF_MAX_BURST = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_grant
// Purpose  : Combinational grant pick plus next owner / burst count / rr pointer.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = DEF_MAX_BURST,
    parameter int unsigned CW        = $clog2(MAX_BURST) + 1
) (
    input  logic [1:0]    req_i,
    input  logic [1:0]    owner_i,
    input  logic [CW-1:0] cnt_i,
    input  logic          rr_i,
    output logic [1:0]    gnt_o,
    output logic [1:0]    owner_o,
    output logic [CW-1:0] cnt_o,
    output logic          rr_o
);

    logic          own_valid;
    logic          own_idx;
    logic          under_limit;
    logic [CW-1:0] cnt_inc;
    logic          sel_valid;
    logic          sel_idx;
    logic [CW-1:0] sel_cnt;

    assign own_valid   = (owner_i != OWN_NONE);
    assign own_idx     = (owner_i == OWN1);
    assign under_limit = (cnt_i < CW'(MAX_BURST));
    assign cnt_inc     = under_limit ? (cnt_i + CW'(1)) : CW'(MAX_BURST);

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = 1'b0;
        sel_cnt   = '0;
        // The owner keeps the port unless the other side waits and the burst is spent.
        if (own_valid && req_i[own_idx] && (!req_i[~own_idx] || under_limit)) begin
            sel_valid = 1'b1;
            sel_idx   = own_idx;
            sel_cnt   = cnt_inc;
        end else if (req_i == 2'b01 || req_i == 2'b10) begin
            sel_valid = 1'b1;
            sel_idx   = req_i[1];
            sel_cnt   = CW'(1);
        end else if (req_i == 2'b11) begin
            sel_valid = 1'b1;
            sel_idx   = ~rr_i;
            sel_cnt   = CW'(1);
        end
    end

    always_comb begin
        gnt_o   = '0;
        owner_o = OWN_NONE;
        cnt_o   = '0;
        rr_o    = rr_i;
        if (sel_valid) begin
            gnt_o[sel_idx] = 1'b1;
            owner_o        = sel_idx ? OWN1 : OWN0;
            cnt_o          = sel_cnt;
            rr_o           = sel_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin, burst-bounded sharing of a single-port memory by two
//            requesters, with address/data steering and per-requester rvalid.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned M         = DEF_M,
    parameter int unsigned N         = DEF_N,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req,
    input  logic [1:0]     we,
    input  logic [2*M-1:0] addr,
    input  logic [2*N-1:0] wdata,
    output logic [1:0]     gnt,
    output logic [1:0]     rvalid,
    output logic [N-1:0]   rdata,
    output logic [M-1:0]   mem_addr,
    output logic           mem_wr_enb,
    output logic [N-1:0]   mem_wr_data,
    input  logic [N-1:0]   mem_rd_data
);

    localparam int unsigned CW = $clog2(MAX_BURST) + 1;

    logic [1:0]    owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rr_q, rr_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [1:0]    gnt_raw;

    mem_arb_grant #(
        .MAX_BURST (MAX_BURST),
        .CW        (CW)
    ) u_grant (
        .req_i   (req),
        .owner_i (owner_q),
        .cnt_i   (cnt_q),
        .rr_i    (rr_q),
        .gnt_o   (gnt_raw),
        .owner_o (owner_d),
        .cnt_o   (cnt_d),
        .rr_o    (rr_d)
    );

    // Reset blocks the port combinationally so nothing reaches the memory while held.
    assign gnt      = rst_n ? gnt_raw : 2'b00;
    assign rvalid_d = gnt & ~we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q  <= OWN_NONE;
            cnt_q    <= '0;
            rr_q     <= 1'b1;
            rvalid_q <= 2'b00;
        end else begin
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_enb  = 1'b0;
        if (gnt[0]) begin
            mem_addr    = addr[0 +: M];
            mem_wr_data = wdata[0 +: N];
            mem_wr_enb  = we[0];
        end else if (gnt[1]) begin
            mem_addr    = addr[M +: M];
            mem_wr_data = wdata[N +: N];
            mem_wr_enb  = we[1];
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = mem_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed plus random checks of mem_port_arbiter against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int M  = 3;
    localparam int N  = 4;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req;
    logic [1:0]     we;
    logic [2*M-1:0] addr;
    logic [2*N-1:0] wdata;
    logic [1:0]     gnt;
    logic [1:0]     rvalid;
    logic [N-1:0]   rdata;
    logic [M-1:0]   mem_addr;
    logic           mem_wr_enb;
    logic [N-1:0]   mem_wr_data;
    logic [N-1:0]   mem_rd_data;

    logic [N-1:0]   tb_mem  [0:(1<<M)-1];
    logic [N-1:0]   ref_mem [0:(1<<M)-1];

    int checks = 0;
    int errors = 0;

    // Reference model state: owner index (-1 none), streak length, last granted index.
    int         m_owner = -1;
    int         m_cnt   = 0;
    int         m_last  = 1;
    int         m_g     = -1;
    logic [1:0] exp_rv  = 2'b00;
    logic [N-1:0] exp_rd = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.M(M), .N(N), .MAX_BURST(MB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .mem_addr    (mem_addr),
        .mem_wr_enb  (mem_wr_enb),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    always @(posedge clk) begin
        if (mem_wr_enb) tb_mem[mem_addr] <= mem_wr_data;
        mem_rd_data <= tb_mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick();
        int x;
        if (!rst_n) return -1;
        if (m_owner >= 0) begin
            x = 1 - m_owner;
            if (req[m_owner] && (!req[x] || m_cnt < MB)) return m_owner;
        end
        if (req == 2'b01) return 0;
        if (req == 2'b10) return 1;
        if (req == 2'b11) return 1 - m_last;
        return -1;
    endfunction

    // One clock: check outputs at negedge, optionally drop reset late, then advance the model.
    task automatic cycle(input bit late_rst, input int want);
        int g;
        @(negedge clk);
        g = model_pick();
        chk("gnt", {30'd0, gnt}, (g < 0) ? 32'd0 : (32'd1 << g));
        chk("mem_addr", {29'd0, mem_addr}, (g < 0) ? 32'd0 : {29'd0, addr[g*M +: M]});
        chk("mem_wr_enb", {31'd0, mem_wr_enb}, (g < 0) ? 32'd0 : {31'd0, we[g]});
        chk("mem_wr_data", {28'd0, mem_wr_data}, (g < 0) ? 32'd0 : {28'd0, wdata[g*N +: N]});
        chk("rvalid", {30'd0, rvalid}, {30'd0, exp_rv});
        if (exp_rv != 2'b00) chk("rdata", {28'd0, rdata}, {28'd0, exp_rd});
        if (want >= 0) chk("plan_gnt", {30'd0, gnt}, want);
        if (late_rst) rst_n = 1'b0;
        @(posedge clk);
        if (!rst_n) begin
            m_owner = -1; m_cnt = 0; m_last = 1; exp_rv = 2'b00; m_g = -1;
        end else if (g >= 0) begin
            m_cnt   = (g == m_owner) ? ((m_cnt < MB) ? m_cnt + 1 : MB) : 1;
            m_owner = g;
            m_last  = g;
            m_g     = g;
            if (we[g]) begin
                ref_mem[addr[g*M +: M]] = wdata[g*N +: N];
                exp_rv = 2'b00;
            end else begin
                exp_rv = 2'(1 << g);
                exp_rd = ref_mem[addr[g*M +: M]];
            end
        end else begin
            m_owner = -1; m_cnt = 0; exp_rv = 2'b00; m_g = -1;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << M); i++) begin
            tb_mem[i]  = N'(i * 3 + 1);
            ref_mem[i] = N'(i * 3 + 1);
        end
        rst_n = 1'b0; req = 2'b11; we = 2'b11;
        addr  = {3'd6, 3'd3}; wdata = {4'h9, 4'h5};
        @(posedge clk); #1;

        // Held reset with both requesters writing: port must stay closed.
        repeat (3) cycle(1'b0, 0);
        rst_n = 1'b1; we = 2'b00;

        // Sustained contention: bursts of MB alternate, req0 first.
        for (int k = 0; k < 16; k++) cycle(1'b0, ((k / MB) % 2) ? 2 : 1);

        // Early release hands over with no idle cycle.
        req = 2'b00; cycle(1'b0, 0);
        req = 2'b01; cycle(1'b0, 1);
        req = 2'b11; cycle(1'b0, 1);
        req = 2'b10; cycle(1'b0, 2);

        // Single client write then read-back of the same address.
        req = 2'b00; cycle(1'b0, 0);
        req = 2'b01; we = 2'b01; addr = {3'd0, 3'd5}; wdata = {4'h0, 4'hA};
        cycle(1'b0, 1);
        we = 2'b00;
        cycle(1'b0, 1);
        req = 2'b00;
        chk("rd_valid", {30'd0, rvalid}, 32'h1);
        chk("rd_data", {28'd0, rdata}, 32'hA);
        cycle(1'b0, 0);

        // Lone requester is never throttled; a newcomer wins at once after saturation.
        req = 2'b01; addr = {3'd1, 3'd4};
        repeat (10) cycle(1'b0, 1);
        req = 2'b11; cycle(1'b0, 2);
        req = 2'b00; cycle(1'b0, 0);

        // Reset lands at the edge ending a granted read: no rvalid may follow.
        req = 2'b01; we = 2'b00; addr = {3'd0, 3'd2};
        cycle(1'b1, 1);
        chk("rst_rvalid", {30'd0, rvalid}, 32'h0);
        req = 2'b11;
        cycle(1'b0, 0);
        rst_n = 1'b1;
        cycle(1'b0, 1);

        // Random traffic; requesters hold their transaction until granted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req[i] || m_g == i) begin
                    req[i]           = ($urandom_range(0, 3) != 0);
                    we[i]            = $urandom_range(0, 1) != 0;
                    addr[i*M +: M]   = M'($urandom_range(0, (1 << M) - 1));
                    wdata[i*N +: N]  = N'($urandom_range(0, (1 << N) - 1));
                end
            end
            cycle(1'b0, -1);
        end

        req = 2'b00;
        cycle(1'b0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
